// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready flow control.
// Stages: classify/unpack, mantissa product, normalise/round/pack into the output registers.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [EW-1:0]    BIAS_V   = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    EMAX_V   = EW'((2 ** EXP_W) - 1);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Class vector layout: {nan, snan, inf, zero}; subnormals count as zero.
  function automatic logic [3:0] classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             nan;
    e   = x[W-2 -: EXP_W];
    f   = x[MAN_W-1:0];
    nan = (e == EXP_ONES) && (f != MAN_ZERO);
    return {nan, nan & ~f[MAN_W-1], (e == EXP_ONES) && (f == MAN_ZERO), e == EXP_ZERO};
  endfunction

  logic              adv_s;

  logic [3:0]        cls_a_s, cls_b_s;
  logic              v1_d, sign1_d;
  logic [3:0]        cls1_d;
  logic [EW-1:0]     esum1_d;
  logic [MAN_W:0]    ma1_d, mb1_d;

  logic              v1_q, sign1_q;
  logic [TAG_W-1:0]  tag1_q;
  logic [3:0]        cls1_q;
  logic [EW-1:0]     esum1_q;
  logic [MAN_W:0]    ma1_q, mb1_q;

  logic [PW-1:0]     prod2_d;
  logic              v2_q, sign2_q;
  logic [TAG_W-1:0]  tag2_q;
  logic [3:0]        cls2_q;
  logic [EW-1:0]     esum2_q;
  logic [PW-1:0]     prod2_q;

  logic [PW-1:0]     norm_s;
  logic [MAN_W:0]    mant_s;
  logic [MAN_W+1:0]  mant_r_s;
  logic [MAN_W-1:0]  frac_s;
  logic              guard_s, sticky_s, round_up_s;
  logic [EW-1:0]     eexp_s;
  logic              ovf_s, unf_s;

  logic [W-1:0]      res_d;
  logic [3:0]        flags_d;
  logic              out_valid_q;
  logic [W-1:0]      out_result_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [3:0]        out_flags_q;

  assign adv_s    = ~out_valid_q | out_ready;
  assign in_ready = adv_s;

  assign cls_a_s  = classify(in_a);
  assign cls_b_s  = classify(in_b);

  // Stage-1 next state: sign, combined operand class, biased exponent sum, hidden-1 mantissas.
  always_comb begin
    v1_d    = in_valid;
    sign1_d = in_a[W-1] ^ in_b[W-1];
    cls1_d  = {cls_a_s[3] | cls_b_s[3], cls_a_s[2] | cls_b_s[2],
               cls_a_s[1] | cls_b_s[1], cls_a_s[0] | cls_b_s[0]};
    esum1_d = {2'b00, in_a[W-2 -: EXP_W]} + {2'b00, in_b[W-2 -: EXP_W]} - BIAS_V;
    ma1_d   = {1'b1, in_a[MAN_W-1:0]};
    mb1_d   = {1'b1, in_b[MAN_W-1:0]};
  end

  // Stage-1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      tag1_q  <= {TAG_W{1'b0}};
      cls1_q  <= 4'b0000;
      esum1_q <= {EW{1'b0}};
      ma1_q   <= {(MAN_W+1){1'b0}};
      mb1_q   <= {(MAN_W+1){1'b0}};
    end else if (adv_s) begin
      v1_q    <= v1_d;
      sign1_q <= sign1_d;
      tag1_q  <= in_tag;
      cls1_q  <= cls1_d;
      esum1_q <= esum1_d;
      ma1_q   <= ma1_d;
      mb1_q   <= mb1_d;
    end
  end

  assign prod2_d = PW'(ma1_q) * PW'(mb1_q);

  // Stage-2 register: full-width mantissa product plus carried operand state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      tag2_q  <= {TAG_W{1'b0}};
      cls2_q  <= 4'b0000;
      esum2_q <= {EW{1'b0}};
      prod2_q <= {PW{1'b0}};
    end else if (adv_s) begin
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      tag2_q  <= tag1_q;
      cls2_q  <= cls1_q;
      esum2_q <= esum1_q;
      prod2_q <= prod2_d;
    end
  end

  // Normalise so the leading one sits at the top bit, then round to nearest even.
  always_comb begin
    norm_s     = prod2_q[PW-1] ? prod2_q : (prod2_q << 1'b1);
    mant_s     = norm_s[PW-1 -: MAN_W+1];
    guard_s    = norm_s[MAN_W];
    sticky_s   = |norm_s[MAN_W-1:0];
    round_up_s = guard_s & (sticky_s | mant_s[0]);
    mant_r_s   = {1'b0, mant_s} + {{(MAN_W+1){1'b0}}, round_up_s};
    frac_s     = mant_r_s[MAN_W+1] ? mant_r_s[MAN_W:1] : mant_r_s[MAN_W-1:0];
    eexp_s     = esum2_q + {{(EW-1){1'b0}}, prod2_q[PW-1]} + {{(EW-1){1'b0}}, mant_r_s[MAN_W+1]};
    ovf_s      = ~eexp_s[EW-1] && (eexp_s >= EMAX_V);
    unf_s      = eexp_s[EW-1] || (eexp_s == {EW{1'b0}});
  end

  // Special-case priority resolution and result packing.
  always_comb begin
    res_d   = {W{1'b0}};
    flags_d = 4'b0000;
    if (cls2_q[3]) begin
      res_d   = QNAN;
      flags_d = {cls2_q[2], 3'b000};
    end else if (cls2_q[1] && cls2_q[0]) begin
      res_d   = QNAN;
      flags_d = 4'b1000;
    end else if (cls2_q[1]) begin
      res_d   = {sign2_q, EXP_ONES, MAN_ZERO};
      flags_d = 4'b0000;
    end else if (cls2_q[0]) begin
      res_d   = {sign2_q, EXP_ZERO, MAN_ZERO};
      flags_d = 4'b0000;
    end else if (ovf_s) begin
      res_d   = {sign2_q, EXP_ONES, MAN_ZERO};
      flags_d = 4'b0101;
    end else if (unf_s) begin
      res_d   = {sign2_q, EXP_ZERO, MAN_ZERO};
      flags_d = 4'b0011;
    end else begin
      res_d   = {sign2_q, eexp_s[EXP_W-1:0], frac_s};
      flags_d = {3'b000, guard_s | sticky_s};
    end
  end

  // Output register: data only changes when a new valid result moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= {W{1'b0}};
      out_tag_q    <= {TAG_W{1'b0}};
      out_flags_q  <= 4'b0000;
    end else if (adv_s) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_result_q <= res_d;
        out_tag_q    <= tag2_q;
        out_flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: expected results queued at issue, compared when delivered.
module tb_fp_mul_pipe;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] in_a      = 32'h0;
  logic [31:0] in_b      = 32'h0;
  logic [3:0]  in_tag    = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;

  localparam int NV = 15;
  vec_t vecs [0:NV-1] = '{
    '{32'h40200000, 32'h40600000, 32'h410C0000, 4'b0000},
    '{32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000},
    '{32'h44FC7333, 32'hFF800001, 32'h7FC00000, 4'b1000},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
    '{32'hFF800000, 32'hFF800000, 32'h7F800000, 4'b0000},
    '{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000},
    '{32'h00000000, 32'h00000000, 32'h00000000, 4'b0000},
    '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101},
    '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001},
    '{32'h3FC00001, 32'h3FC00000, 32'h40100001, 4'b0001},
    '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000},
    '{32'h80000001, 32'h3F800000, 32'h80000000, 4'b0000},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000}
  };

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Called on a negedge; holds the operands until in_ready, queues the expectation, returns on the next negedge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input logic [31:0] res, input logic [3:0] fl);
    int k;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    if (!in_ready) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    sb.push_back('{res: res, tag: tag, flags: fl});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    out_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk); #2;
      k++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  // Scoreboard: every delivered result must match the oldest outstanding expectation.
  always begin
    @(negedge clk); #1;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {32'h0, out_result}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {32'h0, out_result}, {32'h0, mon_e.res});
        chk("tag",    {60'h0, out_tag},    {60'h0, mon_e.tag});
        chk("flags",  {60'h0, out_flags},  {60'h0, mon_e.flags});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_r;
    logic [3:0]  hold_t;
    int          stale;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid",  {63'd0, out_valid},  64'd0);
    chk("rst_out_result", {32'd0, out_result}, 64'd0);
    chk("rst_out_tag",    {60'd0, out_tag},    64'd0);
    chk("rst_out_flags",  {60'd0, out_flags},  64'd0);
    chk("rst_in_ready",   {63'd0, in_ready},   64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    // T1: 2*1 and its exact latency
    send(32'h40000000, 32'h3F800000, 4'hA, 32'h40000000, 4'b0000);
    #1 chk("t1_lat1", {63'd0, out_valid}, 64'd0);
    @(negedge clk); #1 chk("t1_lat2", {63'd0, out_valid}, 64'd0);
    @(negedge clk); #1 chk("t1_lat3", {63'd0, out_valid}, 64'd1);
    @(negedge clk);

    // T2-T4 and extra rounding/special cases, issued back to back
    for (int i = 0; i < NV; i++)
      send(vecs[i].a, vecs[i].b, 4'(i), vecs[i].res, vecs[i].fl);
    drain();

    // T5: fill the pipe against a stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_ready_fill", {63'd0, in_ready}, 64'd1);
      send(32'((127 + i) << 23), 32'h40400000, 4'(i), 32'(((128 + i) << 23) | 32'h00400000), 4'b0000);
    end
    in_a = 32'((127 + 3) << 23); in_b = 32'h40400000; in_tag = 4'd3; in_valid = 1'b1;
    #1;
    chk("t5_in_ready_low", {63'd0, in_ready},  64'd0);
    chk("t5_out_valid",    {63'd0, out_valid}, 64'd1);
    hold_r = out_result;
    hold_t = out_tag;
    repeat (3) begin
      @(negedge clk); #1;
      chk("t5_hold_result", {32'd0, out_result}, {32'd0, hold_r});
      chk("t5_hold_tag",    {60'd0, out_tag},    {60'd0, hold_t});
      chk("t5_still_full",  {63'd0, in_ready},   64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 3; i < 5; i++)
      send(32'((127 + i) << 23), 32'h40400000, 4'(i), 32'(((128 + i) << 23) | 32'h00400000), 4'b0000);
    drain();

    // T6: reset with two operations in flight
    send(vecs[0].a, vecs[0].b, 4'd5, vecs[0].res, vecs[0].fl);
    send(vecs[1].a, vecs[1].b, 4'd6, vecs[1].res, vecs[1].fl);
    @(posedge clk); #2;
    chk("t6_pre_valid", {63'd0, out_valid}, 64'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_valid",  {63'd0, out_valid},  64'd0);
    chk("t6_rst_result", {32'd0, out_result}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid) stale++;
    end
    chk("t6_no_stale", 64'(stale), 64'd0);
    @(negedge clk);
    send(vecs[14].a, vecs[14].b, 4'd7, vecs[14].res, vecs[14].fl);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
